rf_wb_arb: RTL
==============

RF_WB_ARB -- requirements
Module: rf_wb_arb

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of conflict counter.
REQ-002 SHALL have clk  input  1  rising-edge clock.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset; clock clk.
REQ-004 SHALL have hold  input  1  pipeline stall; no grants while high.
REQ-005 SHALL have a_valid  input  1  requester A (ALU writeback) request.
REQ-006 SHALL have a_ready  output  1  A request accepted this cycle.
REQ-007 SHALL have a_reg  input  5  A destination register number.
REQ-008 SHALL have a_data  input  64  A write data.
REQ-009 SHALL have b_valid, b_ready, b_reg, b_data as REQ-005..008 for requester B (load writeback).
REQ-010 SHALL have rf_wReg  output  5  register-file write register number.
REQ-011 SHALL have rf_Data  output  64  register-file write data.
REQ-012 SHALL have rf_RegWrite  output  1  register-file write enable.
REQ-013 SHALL have last_grant  output  1  0=A, 1=B; requester granted most recently.
REQ-014 SHALL have conflict_cnt  output  CNT_W  saturating count of contended grant cycles.

Function
REQ-015 SHALL grant at most one requester per cycle; granted requester's ready is high combinationally in that cycle; transfer occurs when valid and ready both high.
REQ-016 SHALL grant nothing while hold=1 or reset=1; a_ready=b_ready=0.
REQ-017 SHALL grant the sole valid requester when only one is valid.
REQ-018 SHALL, when both valid and hold=0, grant the requester not equal to last_grant (round-robin).
REQ-019 SHALL update last_grant to the granted requester on every transfer; unchanged otherwise.
REQ-020 SHALL register the transfer: rf_RegWrite=1, rf_wReg, rf_Data equal accepted reg/data exactly one cycle after transfer; rf_RegWrite=0 in cycles following no transfer.
REQ-021 SHALL hold rf_wReg and rf_Data at last written values when rf_RegWrite=0.
REQ-022 SHALL keep an ungranted valid request pending; requester must hold valid, reg, data stable until ready.
REQ-023 SHALL, for both requesters targeting the same register, write them in grant order, so the later grant's data is the final register value.
REQ-024 SHALL increment conflict_cnt by 1 each cycle both valid and hold=0; saturate at all-ones without wrap.
REQ-025 SHALL sustain one write per cycle; no idle cycle inserted between back-to-back grants.
REQ-026 SHALL, on hold asserted, complete the write of any transfer from the previous cycle (output stage not stalled).

Reset
REQ-027 SHALL, on clk edge with reset=1, set rf_RegWrite=0, rf_wReg=0, rf_Data=0, last_grant=1 (so A wins first contention), conflict_cnt=0.
REQ-028 SHALL drop any transfer offered in a reset cycle; no write occurs in the cycle after reset.
REQ-029 SHALL, with reset mid-stream, discard pending requests; arbitration restarts from REQ-027 state.

Configuration
REQ-030 SHALL support macro RF_WB_ZERO_GUARD_EN.
REQ-031 SHALL, with RF_WB_ZERO_GUARD_EN defined, accept transfers to register 0 normally (ready, last_grant, conflict_cnt unaffected) but keep rf_RegWrite=0 for them.
REQ-032 SHALL, without RF_WB_ZERO_GUARD_EN, treat register 0 as any other register.

Verification
REQ-033 SHALL cover: reset, then a_valid=1 a_reg=5 a_data=0x11 for one cycle -> a_ready=1 same cycle; next cycle rf_RegWrite=1, rf_wReg=5, rf_Data=0x11.
REQ-034 SHALL cover: a and b both valid (a_reg=3, b_reg=4) for 4 cycles after reset, requests reissued after acceptance -> grants A,B,A,B; conflict_cnt=4; last_grant=1.
REQ-035 SHALL cover: both valid to reg 7, a_data=0xAA, b_data=0xBB, last_grant=0 -> B written first, then A; final writes 0xBB then 0xAA.
REQ-036 SHALL cover: hold=1 for 3 cycles with a_valid=1 -> a_ready=0 all 3 cycles, rf_RegWrite=0; hold released -> grant next cycle.
REQ-037 SHALL cover: CNT_W=2, 6 contended cycles -> conflict_cnt=3, no wrap.
REQ-038 SHALL cover: RF_WB_ZERO_GUARD_EN defined, b_reg=0 b_data=0x55 -> b_ready=1, rf_RegWrite=0 next cycle; undefined -> rf_RegWrite=1, rf_wReg=0, rf_Data=0x55.

Source files
------------

// File: rtl/rf_wb_arb.sv
// Register-file writeback arbiter: round-robin between ALU (A) and load (B) writeback.
// Optional macro RF_WB_ZERO_GUARD_EN suppresses the register-file write for register 0.
module rf_wb_arb #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [4:0]       a_reg,
  input  logic [63:0]      a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [4:0]       b_reg,
  input  logic [63:0]      b_data,
  output logic [4:0]       rf_wReg,
  output logic [63:0]      rf_Data,
  output logic             rf_RegWrite,
  output logic             last_grant,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 64;

  logic              we_q, we_d;
  logic [REG_W-1:0]  wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              live;
  logic              contend;
  logic              xfer;
  logic              commit;
  logic [REG_W-1:0]  sel_reg;
  logic [DATA_W-1:0] sel_data;

  // Grant decision: sole requester wins, contention goes to the one not granted last.
  always_comb begin
    live    = !hold && !reset;
    contend = live && a_valid && b_valid;
    a_ready = live && a_valid && (!b_valid || last_q);
    b_ready = live && b_valid && (!a_valid || !last_q);
    xfer    = a_ready || b_ready;
    sel_reg  = b_ready ? b_reg  : a_reg;
    sel_data = b_ready ? b_data : a_data;
`ifdef RF_WB_ZERO_GUARD_EN
    commit = xfer && (sel_reg != REG_W'(0));
`else
    commit = xfer;
`endif
  end

  always_comb begin
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (commit) begin
      we_d    = 1'b1;
      wreg_d  = sel_reg;
      wdata_d = sel_data;
    end
    if (xfer) begin
      last_d = b_ready;
    end
    if (contend && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Reset leaves last_q=1 so A wins the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rf_RegWrite  = we_q;
  assign rf_wReg      = wreg_q;
  assign rf_Data      = wdata_q;
  assign last_grant   = last_q;
  assign conflict_cnt = cnt_q;

endmodule
